// File: rtl/cycle_sequencer_if.sv
// rtl/cycle_sequencer_if.sv - control, decoder-enable and strobe bundle around the cycle sequencer
interface cycle_sequencer_if;
    logic        RUN;
    logic        STEP;
    logic        nPC_LD;
    logic        nSK_EN;
    logic        SKIP_COND;
    logic        nFA_EN;
    logic        IR_LD;
    logic        OUT_EN;
    logic        ST_PULSE;
    logic        FLAG_LD;
    logic        PC_LD;
    logic        PC_INC;
    logic        BUSY;
    logic [2:0]  STATE;
    logic [15:0] INSTR_CNT;

    modport master (
        output RUN, STEP, nPC_LD, nSK_EN, SKIP_COND, nFA_EN,
        input  IR_LD, OUT_EN, ST_PULSE, FLAG_LD, PC_LD, PC_INC, BUSY, STATE, INSTR_CNT
    );

    modport slave (
        input  RUN, STEP, nPC_LD, nSK_EN, SKIP_COND, nFA_EN,
        output IR_LD, OUT_EN, ST_PULSE, FLAG_LD, PC_LD, PC_INC, BUSY, STATE, INSTR_CNT
    );
endinterface

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - FETCH/DECODE/EXEC/WB(/SKIP) instruction-cycle sequencer with one-clock strobes
module cycle_sequencer #(
    parameter int TICK_DIV = 1,
    parameter int DIV_W    = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    cycle_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        SKIP   = 3'd5
    } seqState_e;

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

    seqState_e        state;
    seqState_e        stateNext;
    logic [DIV_W-1:0] divCnt;
    logic             tick;
    logic             stepMeta;
    logic             stepSync;
    logic             stepSyncQ;
    logic             stepRise;
    logic             pending;
    logic             nPcLdQ;
    logic             nSkEnQ;
    logic             skipCondQ;
    logic             nFaEnQ;
    logic             irLdQ;
    logic             stPulseQ;
    logic             flagLdQ;
    logic             pcLdQ;
    logic             pcIncQ;
    logic [15:0]      instrCnt;
    logic             enterWb;
    logic             enterSkip;
    logic             enterDecode;
    logic             leaveIdle;

    assign tick        = (divCnt == TICK_LAST);
    assign stepRise    = stepSync & ~stepSyncQ;
    assign enterWb     = (state == EXEC) && tick;
    assign enterSkip   = (stateNext == SKIP) && (state != SKIP);
    assign enterDecode = (stateNext == DECODE) && (state != DECODE);
    assign leaveIdle   = (state == IDLE) && (stateNext != IDLE);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:   if (bus.RUN || pending) stateNext = FETCH;
            FETCH:  if (tick) stateNext = DECODE;
            DECODE: if (tick) stateNext = EXEC;
            EXEC:   if (tick) stateNext = WB;
            WB: begin
                // a taken jump overrides the skip condition
                if (tick) begin
                    if (!nSkEnQ && skipCondQ && nPcLdQ) stateNext = SKIP;
                    else if (bus.RUN)                   stateNext = FETCH;
                    else                                stateNext = IDLE;
                end
            end
            SKIP:   if (tick) stateNext = bus.RUN ? FETCH : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            divCnt    <= '0;
            stepMeta  <= 1'b0;
            stepSync  <= 1'b0;
            stepSyncQ <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (state == IDLE || tick) divCnt <= '0;
            else                       divCnt <= divCnt + DIV_W'(1);

            stepMeta  <= bus.STEP;
            stepSync  <= stepMeta;
            stepSyncQ <= stepSync;

            // presses during free-run are dropped; a fresh edge outranks the clear on IDLE exit
            if (bus.RUN)       pending <= 1'b0;
            else if (stepRise) pending <= 1'b1;
            else if (leaveIdle) pending <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            nPcLdQ    <= 1'b0;
            nSkEnQ    <= 1'b0;
            skipCondQ <= 1'b0;
            nFaEnQ    <= 1'b0;
            irLdQ     <= 1'b0;
            stPulseQ  <= 1'b0;
            flagLdQ   <= 1'b0;
            pcLdQ     <= 1'b0;
            pcIncQ    <= 1'b0;
            instrCnt  <= 16'h0000;
        end else begin
            if (enterWb) begin
                nPcLdQ    <= bus.nPC_LD;
                nSkEnQ    <= bus.nSK_EN;
                skipCondQ <= bus.SKIP_COND;
                nFaEnQ    <= bus.nFA_EN;
                instrCnt  <= instrCnt + 16'd1;
            end
            // WB strobes use the same decoder values being captured on this edge
            irLdQ    <= enterDecode;
            stPulseQ <= enterWb;
            flagLdQ  <= enterWb && !bus.nFA_EN;
            pcLdQ    <= enterWb && !bus.nPC_LD;
            pcIncQ   <= (enterWb && bus.nPC_LD) || enterSkip;
        end
    end

    assign bus.IR_LD     = irLdQ;
    assign bus.ST_PULSE  = stPulseQ;
    assign bus.FLAG_LD   = flagLdQ;
    assign bus.PC_LD     = pcLdQ;
    assign bus.PC_INC    = pcIncQ;
    assign bus.OUT_EN    = (state == EXEC) || (state == WB);
    assign bus.BUSY      = (state != IDLE);
    assign bus.STATE     = state;
    assign bus.INSTR_CNT = instrCnt;

    logic unusedFaEn;
    assign unusedFaEn = nFaEnQ;
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - directed self-checking bench for cycle_sequencer
module tb_cycle_sequencer;
    logic CLK;
    logic nRST;
    int   nTests;
    int   nFail;

    cycle_sequencer_if bus1 ();
    cycle_sequencer_if bus3 ();

    cycle_sequencer #(.TICK_DIV(1), .DIV_W(16)) dut1 (.CLK(CLK), .nRST(nRST), .bus(bus1));
    cycle_sequencer #(.TICK_DIV(3), .DIV_W(16)) dut3 (.CLK(CLK), .nRST(nRST), .bus(bus3));

    // {IR_LD, ST_PULSE, FLAG_LD, PC_LD, PC_INC, OUT_EN, BUSY}
    logic [6:0] sv1;
    logic [6:0] sv3;
    assign sv1 = {bus1.IR_LD, bus1.ST_PULSE, bus1.FLAG_LD, bus1.PC_LD, bus1.PC_INC, bus1.OUT_EN, bus1.BUSY};
    assign sv3 = {bus3.IR_LD, bus3.ST_PULSE, bus3.FLAG_LD, bus3.PC_LD, bus3.PC_INC, bus3.OUT_EN, bus3.BUSY};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch();
        bus1.RUN = 1'b1;
        @(negedge CLK);
        bus1.RUN = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nTests = 0;
        nFail  = 0;
        nRST = 1'b0;
        bus1.RUN = 1'b0; bus1.STEP = 1'b0; bus1.nPC_LD = 1'b1; bus1.nSK_EN = 1'b1;
        bus1.SKIP_COND = 1'b0; bus1.nFA_EN = 1'b1;
        bus3.RUN = 1'b0; bus3.STEP = 1'b0; bus3.nPC_LD = 1'b1; bus3.nSK_EN = 1'b1;
        bus3.SKIP_COND = 1'b0; bus3.nFA_EN = 1'b1;

        repeat (2) @(negedge CLK);
        check("rst_state", 32'(bus1.STATE), 32'd0);
        check("rst_strobes", 32'(sv1), 32'h00);
        check("rst_cnt", 32'(bus1.INSTR_CNT), 32'h0000);
        nRST = 1'b1;
        @(negedge CLK);
        check("idle_hold", 32'(bus1.STATE), 32'd0);

        // free run, TICK_DIV=1, adder enabled
        bus1.RUN = 1'b1;
        bus1.nFA_EN = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            check("fr_state", 32'(bus1.STATE), 32'(((i - 1) % 4) + 1));
            case (i % 4)
                1:       check("fr_fetch", 32'(sv1), 32'(7'b0000001));
                2:       check("fr_decode", 32'(sv1), 32'(7'b1000001));
                3:       check("fr_exec", 32'(sv1), 32'(7'b0000011));
                default: check("fr_wb", 32'(sv1), 32'(7'b0110111));
            endcase
        end
        check("fr_cnt", 32'(bus1.INSTR_CNT), 32'd5);
        bus1.RUN = 1'b0;
        @(negedge CLK);
        check("fr_stop_state", 32'(bus1.STATE), 32'd0);
        check("fr_stop_strobes", 32'(sv1), 32'h00);

        // jump with skip also requested: jump wins
        bus1.nPC_LD = 1'b0; bus1.nSK_EN = 1'b0; bus1.SKIP_COND = 1'b1;
        launch();
        check("jmp_fetch", 32'(bus1.STATE), 32'd1);
        repeat (3) @(negedge CLK);
        check("jmp_wb_state", 32'(bus1.STATE), 32'd4);
        check("jmp_wb_strobes", 32'(sv1), 32'(7'b0111011));
        check("jmp_cnt", 32'(bus1.INSTR_CNT), 32'd6);
        @(negedge CLK);
        check("jmp_no_skip", 32'(bus1.STATE), 32'd0);

        // skip taken
        bus1.nPC_LD = 1'b1; bus1.nFA_EN = 1'b1;
        launch();
        repeat (3) @(negedge CLK);
        check("skp_wb_state", 32'(bus1.STATE), 32'd4);
        check("skp_wb_strobes", 32'(sv1), 32'(7'b0100111));
        @(negedge CLK);
        check("skp_state", 32'(bus1.STATE), 32'd5);
        check("skp_strobes", 32'(sv1), 32'(7'b0000101));
        @(negedge CLK);
        check("skp_end", 32'(bus1.STATE), 32'd0);
        check("skp_cnt", 32'(bus1.INSTR_CNT), 32'd7);

        // skip condition false
        bus1.SKIP_COND = 1'b0;
        launch();
        repeat (3) @(negedge CLK);
        check("nsk_wb_strobes", 32'(sv1), 32'(7'b0100111));
        @(negedge CLK);
        check("nsk_end", 32'(bus1.STATE), 32'd0);
        check("nsk_strobes", 32'(sv1), 32'h00);
        bus1.nSK_EN = 1'b1;

        // single step: one 10-CLK STEP pulse
        bus1.STEP = 1'b1;
        repeat (3) @(negedge CLK);
        check("step_lat_idle", 32'(bus1.STATE), 32'd0);
        @(negedge CLK);
        check("step_lat_fetch", 32'(bus1.STATE), 32'd1);
        repeat (6) @(negedge CLK);
        bus1.STEP = 1'b0;
        repeat (4) @(negedge CLK);
        check("step_end", 32'(bus1.STATE), 32'd0);
        check("step_cnt", 32'(bus1.INSTR_CNT), 32'd9);

        // STEP pressed during WB queues another instruction
        launch();
        repeat (3) @(negedge CLK);
        check("stwb_wb", 32'(bus1.STATE), 32'd4);
        bus1.STEP = 1'b1;
        repeat (3) @(negedge CLK);
        bus1.STEP = 1'b0;
        check("stwb_idle", 32'(bus1.STATE), 32'd0);
        @(negedge CLK);
        check("stwb_refetch", 32'(bus1.STATE), 32'd1);
        repeat (5) @(negedge CLK);
        check("stwb_end", 32'(bus1.STATE), 32'd0);
        check("stwb_cnt", 32'(bus1.INSTR_CNT), 32'd11);

        // STEP during free run is discarded
        bus1.RUN = 1'b1;
        bus1.STEP = 1'b1;
        @(negedge CLK);
        repeat (3) @(negedge CLK);
        bus1.STEP = 1'b0;
        repeat (2) @(negedge CLK);
        bus1.RUN = 1'b0;
        repeat (7) @(negedge CLK);
        check("strun_end", 32'(bus1.STATE), 32'd0);
        check("strun_cnt", 32'(bus1.INSTR_CNT), 32'd13);

        // TICK_DIV=3, RUN dropped in DECODE
        bus3.RUN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            check("t3_state", 32'(bus3.STATE), 32'((i / 3) + 1));
            if (i == 3)       check("t3_irld", 32'(sv3), 32'(7'b1000001));
            else if (i == 9)  check("t3_wb", 32'(sv3), 32'(7'b0100111));
            else if (i >= 6)  check("t3_out", 32'(sv3), 32'(7'b0000011));
            else              check("t3_quiet", 32'(sv3), 32'(7'b0000001));
            if (i == 3) bus3.RUN = 1'b0;
        end
        @(negedge CLK);
        check("t3_end", 32'(bus3.STATE), 32'd0);
        check("t3_cnt", 32'(bus3.INSTR_CNT), 32'd1);

        // reset in EXEC with counter preloaded
        force dut1.instrCnt = 16'hFFFF;
        @(negedge CLK);
        release dut1.instrCnt;
        check("pre_cnt", 32'(bus1.INSTR_CNT), 32'h0000FFFF);
        bus1.nFA_EN = 1'b0;
        launch();
        repeat (2) @(negedge CLK);
        check("rx_exec", 32'(bus1.STATE), 32'd3);
        #2 nRST = 1'b0;
        #1;
        check("rx_state", 32'(bus1.STATE), 32'd0);
        check("rx_strobes", 32'(sv1), 32'h00);
        check("rx_cnt", 32'(bus1.INSTR_CNT), 32'h0000);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        check("rx_after", 32'(bus1.STATE), 32'd0);

        // counter wrap
        force dut1.instrCnt = 16'hFFFF;
        @(negedge CLK);
        release dut1.instrCnt;
        launch();
        repeat (3) @(negedge CLK);
        check("wrap_wb", 32'(bus1.STATE), 32'd4);
        check("wrap_cnt", 32'(bus1.INSTR_CNT), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
